rgmii_tx_if: RTL
================

RGMII_TX_IF -- requirements
Module: rgmii_tx_if

Interface
REQ-001 Parameter: PLATFORM, "SIM", target selection passed unchanged to the oddr instances ("SIM"/"GENERIC" use the behavioural model).
REQ-002 clk  in  1  single transmit clock, 125 MHz nominal; all logic on posedge except oddr output muxing.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 gmii_txd  in  8  transmit byte from MAC.
REQ-005 gmii_tx_en  in  1  frame valid.
REQ-006 gmii_tx_er  in  1  transmit error.
REQ-007 speed  in  2  2'b00 = 10M, 2'b01 = 100M, 2'b10/2'b11 = 1000M.
REQ-008 gmii_tx_clk_en  out  1  byte-accept strobe; MAC byte is sampled in each cycle where this is high.
REQ-009 rgmii_tx_clk  out  1  DDR-generated transmit clock.
REQ-010 rgmii_txd  out  4  DDR data.
REQ-011 rgmii_tx_ctl  out  1  DDR control: TX_EN on the high half, TX_EN^TX_ER on the low half.

Function
REQ-012 Each output pin SHALL be driven by an oddr instance: d1/d2 captured at posedge; q = d1 while clk high, d2 while clk low.
REQ-013 1000M: gmii_tx_clk_en SHALL be 1 every cycle; txd d1 = byte[3:0], d2 = byte[7:4]; clk d1=1, d2=0.
REQ-014 1000M latency: a byte sampled in cycle N SHALL appear on pins during cycle N+2 (one staging register plus oddr).
REQ-015 10/100: a period counter SHALL run 0..4 (100M) or 0..49 (10M), wrapping to 0.
REQ-016 100M clock: high for counts 0, 1 and the d1 half of count 2; low otherwise (2.5/2.5-cycle duty). 10M clock: high for counts 0..24, low for counts 25..49.
REQ-017 10/100 data SHALL be SDR: d1 = d2 = current nibble, updated only at count 0; low nibble in the first period, high nibble in the second.
REQ-018 10/100 nibble-phase bit SHALL toggle at each counter wrap; gmii_tx_clk_en SHALL pulse for one cycle at count 0 with phase 0, i.e. once per 10 cycles (100M) or per 100 cycles (10M).
REQ-019 tx_ctl in 10/100 SHALL be taken from the latched byte's tx_en/tx_er and held for both nibble periods.
REQ-020 Speed change SHALL take effect only at the next byte boundary; the counter and nibble phase then restart from 0 with an accept strobe in that cycle.
REQ-021 Between accept strobes the input is ignored; the latched byte SHALL NOT change.

Reset
REQ-022 During rst, all oddr d1/d2 inputs SHALL be 0; counter, phase, staging registers and gmii_tx_clk_en SHALL be 0.
REQ-023 After rst deasserts, the first accept strobe SHALL occur in the first cycle after reset, in all speeds.
REQ-024 A reset asserted mid-byte SHALL abort the byte immediately; no partial nibble completes after reset.

Structure
REQ-025 Speed encodings (SPEED_10/100/1000) and counter limits (5, 50) SHALL live in a shared package.
REQ-026 Sub-module oddr (PLATFORM, WIDTH) SHALL be the natural counterpart of the existing input DDR block, instantiated with WIDTH 4 (txd) and WIDTH 1 (ctl, clk).

Verification
REQ-027 1000M, bytes 0x5D, 0xA3 on consecutive cycles with tx_en=1 -> pins 2 cycles later: txd D,5 then 3,A; ctl 1,1; clk_en constant 1.
REQ-028 100M, byte 0x5D, tx_en=1, tx_er=1 -> txd 4'hD for 5 cycles then 4'h5 for 5 cycles; ctl high half 1, low half 0; clk_en period 10.
REQ-029 10M idle -> rgmii_tx_clk high 25 cycles, low 25; clk_en period 100; txd 0, ctl 0.
REQ-030 Speed 1000M->100M asserted mid-stream -> change only at next accept strobe, counter restarts at 0, no short clock pulse.
REQ-031 rst pulsed during the second nibble at 10M -> all pins 0 during reset, accept strobe in the first cycle after release.

Source files
------------

// File: rtl/rgmii_tx_if_pkg.sv
// Shared constants and helpers for the RGMII transmit interface.
package rgmii_tx_if_pkg;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  // Period counter lengths, in clk cycles, for one nibble period.
  localparam int unsigned CNT_LIMIT_100 = 5;
  localparam int unsigned CNT_LIMIT_10  = 50;
  localparam int unsigned CNT_W         = 6;

  // Values presented to the output DDR cells for one clk cycle.
  typedef struct packed {
    logic [3:0] txd_d1;
    logic [3:0] txd_d2;
    logic       ctl_d1;
    logic       ctl_d2;
    logic       clk_d1;
    logic       clk_d2;
  } pin_stage_t;

  // 2'b10 and 2'b11 both select gigabit.
  function automatic logic is_gig(input logic [1:0] spd);
    return spd >= SPEED_1000;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_last(input logic [1:0] spd);
    return (spd == SPEED_100) ? CNT_W'(CNT_LIMIT_100 - 1) : CNT_W'(CNT_LIMIT_10 - 1);
  endfunction

  // {d1, d2} of the forwarded clock at a given count; 100M splits count 2 across the halves.
  function automatic logic [1:0] slow_clk(input logic [1:0] spd, input logic [CNT_W-1:0] cnt);
    if (spd == SPEED_100) begin
      if (cnt < CNT_W'(2)) return 2'b11;
      if (cnt == CNT_W'(2)) return 2'b10;
      return 2'b00;
    end
    return (cnt < CNT_W'(CNT_LIMIT_10 / 2)) ? 2'b11 : 2'b00;
  endfunction

endpackage

// File: rtl/rgmii_tx_if_oddr.sv
// Output DDR cell: d1/d2 registered on posedge, q shows d1 while clk is high and d2 while low.
module rgmii_tx_if_oddr #(
  parameter string       PLATFORM = "SIM",
  parameter int unsigned WIDTH    = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] q
);

  // Only the behavioural model exists; other targets need a vendor primitive here.
  if (PLATFORM != "SIM" && PLATFORM != "GENERIC") begin : g_unsupported
    $error("rgmii_tx_if_oddr: unsupported PLATFORM %s", PLATFORM);
  end

  logic [WIDTH-1:0] d1_q;
  logic [WIDTH-1:0] d2_q;

  // Capture both halves together on the rising edge.
  always_ff @(posedge clk) begin
    d1_q <= d1;
    d2_q <= d2;
  end

  // Half-cycle output selection by the clock level.
  always_comb begin
    q = clk ? d1_q : d2_q;
  end

endmodule

// File: rtl/rgmii_tx_if.sv
// GMII to RGMII transmit adapter for 10/100/1000 with byte-accept strobe towards the MAC.
module rgmii_tx_if #(
  parameter string PLATFORM = "SIM"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gmii_txd,
  input  logic       gmii_tx_en,
  input  logic       gmii_tx_er,
  input  logic [1:0] speed,
  output logic       gmii_tx_clk_en,
  output logic       rgmii_tx_clk,
  output logic [3:0] rgmii_txd,
  output logic       rgmii_tx_ctl
);
  import rgmii_tx_if_pkg::*;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [1:0]       speed_q, speed_d;
  logic [7:0]       byte_q, byte_d;
  logic             en_q, en_d, er_q, er_d;
  pin_stage_t       stage_q, stage_d;

  logic             accept;
  logic [1:0]       eff_speed;
  logic [7:0]       sel_byte;
  logic             sel_en, sel_er;
  logic [3:0]       nib;

  // Accept strobe, speed selection and next-state for counter, latched byte and pin stage.
  always_comb begin
    // Gigabit accepts every cycle; 10/100 only at the start of the low-nibble period.
    accept    = !rst && (is_gig(speed_q) || (cnt_q == '0 && !phase_q));
    // A new speed is honoured only on the cycle that accepts a byte.
    eff_speed = accept ? speed : speed_q;
    sel_byte  = accept ? gmii_txd : byte_q;
    sel_en    = accept ? gmii_tx_en : en_q;
    sel_er    = accept ? gmii_tx_er : er_q;
    nib       = phase_q ? sel_byte[7:4] : sel_byte[3:0];

    cnt_d   = cnt_q;
    phase_d = phase_q;
    speed_d = speed_q;
    byte_d  = byte_q;
    en_d    = en_q;
    er_d    = er_q;
    stage_d = stage_q;

    if (accept) begin
      byte_d  = gmii_txd;
      en_d    = gmii_tx_en;
      er_d    = gmii_tx_er;
      speed_d = speed;
      phase_d = 1'b0;
      // This cycle is count 0; gigabit parks the counter there.
      cnt_d   = is_gig(speed) ? '0 : CNT_W'(1);
    end else if (cnt_q == cnt_last(speed_q)) begin
      cnt_d   = '0;
      phase_d = !phase_q;
    end else begin
      cnt_d   = cnt_q + 1'b1;
    end

    if (is_gig(eff_speed)) begin
      stage_d.txd_d1 = sel_byte[3:0];
      stage_d.txd_d2 = sel_byte[7:4];
      stage_d.ctl_d1 = sel_en;
      stage_d.ctl_d2 = sel_en ^ sel_er;
      stage_d.clk_d1 = 1'b1;
      stage_d.clk_d2 = 1'b0;
    end else begin
      {stage_d.clk_d1, stage_d.clk_d2} = slow_clk(eff_speed, cnt_q);
      // SDR data: the nibble and control only move at the start of a nibble period.
      if (cnt_q == '0) begin
        stage_d.txd_d1 = nib;
        stage_d.txd_d2 = nib;
        stage_d.ctl_d1 = sel_en;
        stage_d.ctl_d2 = sel_en ^ sel_er;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      speed_q <= SPEED_10;
      byte_q  <= '0;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      stage_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      speed_q <= speed_d;
      byte_q  <= byte_d;
      en_q    <= en_d;
      er_q    <= er_d;
      stage_q <= stage_d;
    end
  end

  assign gmii_tx_clk_en = accept;

  // Forcing the DDR inputs low during reset aborts any byte in flight at the next edge.
  rgmii_tx_if_oddr #(.PLATFORM(PLATFORM), .WIDTH(4)) u_oddr_txd (
    .clk (clk),
    .d1  (rst ? 4'h0 : stage_q.txd_d1),
    .d2  (rst ? 4'h0 : stage_q.txd_d2),
    .q   (rgmii_txd)
  );

  rgmii_tx_if_oddr #(.PLATFORM(PLATFORM), .WIDTH(1)) u_oddr_ctl (
    .clk (clk),
    .d1  (!rst && stage_q.ctl_d1),
    .d2  (!rst && stage_q.ctl_d2),
    .q   (rgmii_tx_ctl)
  );

  rgmii_tx_if_oddr #(.PLATFORM(PLATFORM), .WIDTH(1)) u_oddr_clk (
    .clk (clk),
    .d1  (!rst && stage_q.clk_d1),
    .d2  (!rst && stage_q.clk_d2),
    .q   (rgmii_tx_clk)
  );

endmodule
